ifchain_status_monitor: RTL and testbench
=========================================

# ifchain_status_monitor

Downstream consumer of the `ifchain` comparator. It takes the comparator's single-bit `status` output and the operands `a`/`b` that produced it. It counts `status` rising edges and detects a sustained assertion of `HOLD` consecutive cycles. On that condition it latches a trip flag and snapshots the operands. The result is visible to the bench and to upstream control until software issues `clear`.

## Interface
- `CNT_W`, default 8: width of the rising-edge counter. Legal range 2..16.
- `HOLD`, default 3: number of consecutive `status`=1 samples required to trip. Legal range 1..15.

Ports, clock and reset first:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `status`  in  1  comparator result. Synchronous to `clk`.
- `a`  in  4  operand A as presented to the comparator.
- `b`  in  4  operand B as presented to the comparator.
- `clear`  in  1  synchronous clear. Zeroes the counter, releases the trip and re-arms.
- `rise_cnt`  out  CNT_W  saturating count of `status` rising edges.
- `tripped`  out  1  high while the state is TRIP.
- `trip_pulse`  out  1  one-cycle pulse on entry to TRIP.
- `snap_a`  out  4  value of `a` sampled on the tripping edge.
- `snap_b`  out  4  value of `b` sampled on the tripping edge.

## Operation
- Reset values: `rise_cnt`=0, `tripped`=0, `trip_pulse`=0, `snap_a`=0, `snap_b`=0. Internal `status_q`=0, `run`=0, state=IDLE.
- Edge detect: `rise` = `status` & ~`status_q`. `status_q` is registered every cycle, including in TRIP and during `clear`.
- Edge counter:
  - `rise` increments `rise_cnt` by 1.
  - At all-ones the counter holds; it never wraps.
  - `clear` zeroes it. When `clear` and `rise` occur in the same cycle, `clear` wins and the result is 0.
- `run` width is `$clog2(HOLD+1)` bits. It counts consecutive samples with `status`=1.
- State machine, three states:
  - IDLE: if `status`=1, go to RUN with `run`=1. If `HOLD`=1, go straight to TRIP instead.
  - RUN: if `status`=0, go to IDLE with `run`=0. If `status`=1 and `run`=`HOLD`-1, go to TRIP. Otherwise increment `run`.
  - TRIP: hold regardless of `status`. `clear` sends the machine to IDLE with `run`=0.
- On every transition into TRIP: capture `snap_a`/`snap_b` from `a`/`b`, and set `trip_pulse` for exactly one cycle.
- `snap_a`/`snap_b` hold their values until the next trip or `rst`. `clear` does not zero them.
- `clear` in IDLE or RUN: state goes to IDLE with `run`=0. The current `status` sample is discarded for run counting. The edge counter is zeroed as above.
- `rst` asserted mid-run or in TRIP: all registers return to reset values immediately, without waiting for a clock edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- `rise_cnt` updates on the edge that samples the rising `status`, so it is visible one cycle later.
- Trip latency: `status` sampled high on edges k .. k+`HOLD`-1 sets `tripped`=1 and `trip_pulse`=1 after edge k+`HOLD`-1. `trip_pulse` drops after edge k+`HOLD`.
- `clear` sampled on edge m sets `tripped`=0 after edge m. The earliest re-trip uses `status` samples from edge m+1 onward.
- A `status` glitch, i.e. 0 for one sample inside a run, restarts the count from that point.

## Structure
- Shared package `ifchain_pkg`:
  - state enum `mon_state_t` with values IDLE, RUN, TRIP.
  - operand width constant `IFC_OP_W`=4, shared with the comparator.
  - default constants `IFC_HOLD_DEF`=3 and `IFC_CNT_W_DEF`=8.
- One natural sub-module, `status_edge_det`. It holds the registered `status_q`, outputs the `rise` pulse, and takes `clk`/`rst`.
- The counter, FSM and snapshot registers live in the top module.

## Test plan
- Reset, then 5 idle cycles with `status`=0 -> all outputs 0 and state IDLE.
- `HOLD`=3, `a`=10, `b`=8, `status` high for 3 cycles -> `tripped`=1 and a single `trip_pulse` after the third edge; `snap_a`=10, `snap_b`=8; `rise_cnt`=1.
- `status` pattern 1,1,0,1,1,0 with `HOLD`=3 -> never trips; `rise_cnt`=2.
- `CNT_W`=2, 5 rising edges separated by `status`=0 gaps that never reach `HOLD` -> `rise_cnt` saturates at 3.
- In TRIP, pulse `clear` in the same cycle as a `status` rise -> `rise_cnt`=0 and `tripped`=0. After 3 more cycles of `status` high -> trips again.
- Assert `rst` asynchronously mid-RUN (`run`=2) -> all outputs read 0 before the next clock edge; the next run needs a full `HOLD` samples.

Source files
------------

// File: rtl/ifchain_pkg.sv
// ifchain_pkg: shared types and constants for the ifchain comparator and its status monitor
package ifchain_pkg;
    typedef enum logic [1:0] {IDLE, RUN, TRIP} mon_state_t;
    localparam int IFC_OP_W = 4;
    localparam int IFC_HOLD_DEF = 3;
    localparam int IFC_CNT_W_DEF = 8;
endpackage

// File: rtl/ifchain_status_monitor_if.sv
// ifchain_status_monitor_if: comparator-side inputs and monitor results bundled as one port
interface ifchain_status_monitor_if #(parameter int CNT_W = ifchain_pkg::IFC_CNT_W_DEF);
    logic status;
    logic clear;
    logic [ifchain_pkg::IFC_OP_W-1:0] a;
    logic [ifchain_pkg::IFC_OP_W-1:0] b;
    logic [CNT_W-1:0] rise_cnt;
    logic tripped;
    logic trip_pulse;
    logic [ifchain_pkg::IFC_OP_W-1:0] snap_a;
    logic [ifchain_pkg::IFC_OP_W-1:0] snap_b;
    modport master (output status, clear, a, b, input rise_cnt, tripped, trip_pulse, snap_a, snap_b);
    modport slave (input status, clear, a, b, output rise_cnt, tripped, trip_pulse, snap_a, snap_b);
endinterface

// File: rtl/ifchain_status_monitor_status_edge_det.sv
// status_edge_det: registers status every cycle and flags its rising edge
module status_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic status,
    output logic rise
);
    logic status_q, status_d;
    // Next value is simply the current sample; it is never gated by clear or trip
    always_comb status_d = status;
    // Previous-sample register
    always_ff @(posedge clk or posedge rst)
        if (rst) status_q <= 1'b0;
        else     status_q <= status_d;
    assign rise = status & ~status_q;
endmodule

// File: rtl/ifchain_status_monitor.sv
// ifchain_status_monitor: counts status rises, trips on HOLD consecutive highs, snapshots operands
module ifchain_status_monitor
    import ifchain_pkg::*;
#(
    parameter int CNT_W = IFC_CNT_W_DEF,
    parameter int HOLD  = IFC_HOLD_DEF
) (
    input logic clk,
    input logic rst,
    ifchain_status_monitor_if.slave bus
);
    localparam int RUN_W = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HOLD - 1);

    mon_state_t state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic trip_pulse_q, trip_pulse_d;
    logic [IFC_OP_W-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
    logic rise;

    status_edge_det u_edge (.clk(clk), .rst(rst), .status(bus.status), .rise(rise));

    // Saturating edge counter, run-length FSM and snapshot capture on TRIP entry
    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        trip_pulse_d = 1'b0;
        snap_a_d     = snap_a_q;
        snap_b_d     = snap_b_q;
        cnt_d        = bus.clear ? '0 : (rise && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        if (bus.clear) begin
            state_d = IDLE;
            run_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.status) begin
                    state_d = (HOLD == 1) ? TRIP : RUN;
                    run_d   = RUN_W'(1);
                end
                RUN: if (!bus.status) begin
                    state_d = IDLE;
                    run_d   = '0;
                end else if (run_q == RUN_LAST) state_d = TRIP;
                else run_d = run_q + RUN_W'(1);
                default: ;
            endcase
        end
        if (state_d == TRIP && state_q != TRIP) begin
            trip_pulse_d = 1'b1;
            snap_a_d     = bus.a;
            snap_b_d     = bus.b;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            run_q        <= '0;
            cnt_q        <= '0;
            trip_pulse_q <= 1'b0;
            snap_a_q     <= '0;
            snap_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            cnt_q        <= cnt_d;
            trip_pulse_q <= trip_pulse_d;
            snap_a_q     <= snap_a_d;
            snap_b_q     <= snap_b_d;
        end

    assign bus.rise_cnt   = cnt_q;
    assign bus.tripped    = (state_q == TRIP);
    assign bus.trip_pulse = trip_pulse_q;
    assign bus.snap_a     = snap_a_q;
    assign bus.snap_b     = snap_b_q;
endmodule

// File: tb/tb_ifchain_status_monitor.sv
// tb_ifchain_status_monitor: table, directed and random checks of three monitor configurations
module tb_ifchain_status_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st = 1'b0, clr = 1'b0;
    logic [3:0] av = 4'd0, bv = 4'd0;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    ifchain_status_monitor_if #(.CNT_W(8)) if0 ();
    ifchain_status_monitor_if #(.CNT_W(2)) if1 ();
    ifchain_status_monitor_if #(.CNT_W(4)) if2 ();

    assign if0.status = st; assign if0.clear = clr; assign if0.a = av; assign if0.b = bv;
    assign if1.status = st; assign if1.clear = clr; assign if1.a = av; assign if1.b = bv;
    assign if2.status = st; assign if2.clear = clr; assign if2.a = av; assign if2.b = bv;

    ifchain_status_monitor #(.CNT_W(8), .HOLD(3)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    ifchain_status_monitor #(.CNT_W(2), .HOLD(3)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    ifchain_status_monitor #(.CNT_W(4), .HOLD(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Packed view: cnt[25:10] tripped[9] pulse[8] snap_a[7:4] snap_b[3:0]
    logic [31:0] g [3];
    assign g[0] = {6'd0, 16'(if0.rise_cnt), if0.tripped, if0.trip_pulse, if0.snap_a, if0.snap_b};
    assign g[1] = {6'd0, 16'(if1.rise_cnt), if1.tripped, if1.trip_pulse, if1.snap_a, if1.snap_b};
    assign g[2] = {6'd0, 16'(if2.rise_cnt), if2.tripped, if2.trip_pulse, if2.snap_a, if2.snap_b};

    // Reference model: per configuration, sample-level rules from the behaviour description
    int p_w [3] = '{8, 2, 4};
    int p_h [3] = '{3, 3, 1};
    int m_cnt [3], m_ones [3];
    bit m_trip [3], m_pulse [3];
    logic [3:0] m_sa [3], m_sb [3];
    bit m_prev;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_ones[i] = 0; m_trip[i] = 0; m_pulse[i] = 0; m_sa[i] = 0; m_sb[i] = 0;
        end
        m_prev = 0;
    endfunction

    function automatic void model_step(bit s, logic [3:0] x, logic [3:0] y, bit c);
        for (int i = 0; i < 3; i++) begin
            int maxc = (1 << p_w[i]) - 1;
            m_pulse[i] = 0;
            if (c) begin
                m_cnt[i] = 0; m_trip[i] = 0; m_ones[i] = 0;
            end else begin
                if (s && !m_prev) m_cnt[i] = (m_cnt[i] + 1 > maxc) ? maxc : m_cnt[i] + 1;
                if (!m_trip[i]) begin
                    m_ones[i] = s ? m_ones[i] + 1 : 0;
                    if (m_ones[i] >= p_h[i]) begin
                        m_trip[i] = 1; m_pulse[i] = 1; m_sa[i] = x; m_sb[i] = y; m_ones[i] = 0;
                    end
                end
            end
        end
        m_prev = s;
    endfunction

    function automatic logic [31:0] exp_v(int i);
        return {6'd0, 16'(m_cnt[i]), m_trip[i], m_pulse[i], m_sa[i], m_sb[i]};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic cyc(string name, logic s, logic [3:0] x, logic [3:0] y, logic c);
        st = s; av = x; bv = y; clr = c;
        @(posedge clk);
        #1;
        model_step(s, x, y, c);
        for (int i = 0; i < 3; i++) check($sformatf("%s dut%0d", name, i), g[i], exp_v(i));
    endtask

    typedef struct {
        logic s; logic [3:0] a, b; logic c;
        logic [7:0] cnt; logic t, p; logic [3:0] sa, sb;
    } vec_t;
    vec_t tv [11];

    initial begin
        tv[0]  = '{1'b1, 4'd10, 4'd8, 1'b0, 8'd1, 1'b0, 1'b0, 4'd0,  4'd0};
        tv[1]  = '{1'b1, 4'd10, 4'd8, 1'b0, 8'd1, 1'b0, 1'b0, 4'd0,  4'd0};
        tv[2]  = '{1'b1, 4'd10, 4'd8, 1'b0, 8'd1, 1'b1, 1'b1, 4'd10, 4'd8};
        tv[3]  = '{1'b1, 4'd3,  4'd5, 1'b0, 8'd1, 1'b1, 1'b0, 4'd10, 4'd8};
        tv[4]  = '{1'b0, 4'd0,  4'd0, 1'b1, 8'd0, 1'b0, 1'b0, 4'd10, 4'd8};
        tv[5]  = '{1'b1, 4'd1,  4'd2, 1'b0, 8'd1, 1'b0, 1'b0, 4'd10, 4'd8};
        tv[6]  = '{1'b1, 4'd1,  4'd2, 1'b0, 8'd1, 1'b0, 1'b0, 4'd10, 4'd8};
        tv[7]  = '{1'b0, 4'd1,  4'd2, 1'b0, 8'd1, 1'b0, 1'b0, 4'd10, 4'd8};
        tv[8]  = '{1'b1, 4'd1,  4'd2, 1'b0, 8'd2, 1'b0, 1'b0, 4'd10, 4'd8};
        tv[9]  = '{1'b1, 4'd1,  4'd2, 1'b0, 8'd2, 1'b0, 1'b0, 4'd10, 4'd8};
        tv[10] = '{1'b0, 4'd1,  4'd2, 1'b0, 8'd2, 1'b0, 1'b0, 4'd10, 4'd8};

        model_reset();
        #2;
        for (int i = 0; i < 3; i++) check($sformatf("reset dut%0d", i), g[i], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 4'd0, 4'd0, 1'b0);

        foreach (tv[k]) begin
            cyc($sformatf("row%0d", k), tv[k].s, tv[k].a, tv[k].b, tv[k].c);
            check($sformatf("table row%0d", k), g[0],
                  {6'd0, 16'(tv[k].cnt), tv[k].t, tv[k].p, tv[k].sa, tv[k].sb});
        end

        cyc("sat clr", 1'b0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc("sat hi", 1'b1, 4'd4, 4'd4, 1'b0);
            cyc("sat lo", 1'b0, 4'd4, 4'd4, 1'b0);
        end
        check("saturate cnt2", 32'(g[1][25:10]), 32'd3);
        check("saturate cnt8", 32'(g[0][25:10]), 32'd5);

        for (int i = 0; i < 3; i++) cyc("trip2", 1'b1, 4'd7, 4'd9, 1'b0);
        check("trip2 tripped", 32'(g[0][9]), 32'd1);
        check("trip2 snap", 32'(g[0][7:0]), 32'h79);
        cyc("trip hold", 1'b0, 4'd0, 4'd0, 1'b0);
        cyc("clr+rise", 1'b1, 4'd0, 4'd0, 1'b1);
        check("clr+rise cnt", 32'(g[0][25:10]), 32'd0);
        check("clr+rise tripped", 32'(g[0][9]), 32'd0);
        cyc("retrip1", 1'b1, 4'd2, 4'd3, 1'b0);
        cyc("retrip2", 1'b1, 4'd2, 4'd3, 1'b0);
        check("retrip early", 32'(g[0][9]), 32'd0);
        cyc("retrip3", 1'b1, 4'd2, 4'd3, 1'b0);
        check("retrip tripped+pulse", 32'(g[0][9:8]), 32'd3);

        cyc("ar clr", 1'b0, 4'd0, 4'd0, 1'b1);
        cyc("ar idle", 1'b0, 4'd0, 4'd0, 1'b0);
        cyc("ar run1", 1'b1, 4'd5, 4'd6, 1'b0);
        cyc("ar run2", 1'b1, 4'd5, 4'd6, 1'b0);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("async reset dut%0d", i), g[i], 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("post rst1", 1'b1, 4'd5, 4'd6, 1'b0);
        cyc("post rst2", 1'b1, 4'd5, 4'd6, 1'b0);
        check("post rst no trip", 32'(g[0][9]), 32'd0);
        cyc("post rst3", 1'b1, 4'd5, 4'd6, 1'b0);
        check("post rst trip", 32'(g[0][9]), 32'd1);

        for (int i = 0; i < 600; i++)
            cyc("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                1'($urandom_range(0, 15) == 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
